// File: rtl/load_store_controller_if.sv
// rtl/load_store_controller_if.sv - core request/response and RAM port bundle for load_store_controller
// master: the controller; slave: the core and RAM environment driving it.
interface load_store_controller_if;
  logic        Start;
  logic        IsMemoryRead;
  logic        IsMemoryWrite;
  logic [1:0]  MemoryAccessWidth;
  logic        MemoryAccessSignExtend;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic [31:0] LoadResult;
  logic [1:0]  FaultCode;
  logic        RamRequest;
  logic        RamWriteEnable;
  logic [29:0] RamAddress;
  logic [3:0]  RamByteEnable;
  logic [31:0] RamWriteData;
  logic        RamReady;
  logic [31:0] RamReadData;

  modport master (
    input  Start, IsMemoryRead, IsMemoryWrite, MemoryAccessWidth, MemoryAccessSignExtend,
    input  Address, StoreData, RamReady, RamReadData,
    output Busy, Done, LoadResult, FaultCode,
    output RamRequest, RamWriteEnable, RamAddress, RamByteEnable, RamWriteData
  );

  modport slave (
    output Start, IsMemoryRead, IsMemoryWrite, MemoryAccessWidth, MemoryAccessSignExtend,
    output Address, StoreData, RamReady, RamReadData,
    input  Busy, Done, LoadResult, FaultCode,
    input  RamRequest, RamWriteEnable, RamAddress, RamByteEnable, RamWriteData
  );
endinterface

// File: rtl/load_store_controller.sv
// rtl/load_store_controller.sv - single-access load/store controller between core and word RAM
// Optional RAM wait timeout (fault 2) enabled by defining LOAD_STORE_TIMEOUT_EN.
module load_store_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                    Clock,
  input logic                    ResetN,
  load_store_controller_if.master bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  localparam logic [1:0] FAULT_NONE       = 2'd0;
  localparam logic [1:0] FAULT_MISALIGNED = 2'd1;
  localparam logic [1:0] FAULT_INVALID    = 2'd3;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  generate
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 2..255");
    end
  endgenerate

`ifdef LOAD_STORE_TIMEOUT_EN
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;
  localparam logic [7:0] TIMEOUT_LAST  = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_count;
`endif

  logic [1:0]  state;
  logic        lat_write;
  logic [1:0]  lat_width;
  logic        lat_sext;
  logic [1:0]  lat_offset;

  logic        invalid_req;
  logic        misaligned_req;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_fmt;

  always_comb begin
    invalid_req    = (bus.IsMemoryRead == bus.IsMemoryWrite) || (bus.MemoryAccessWidth == 2'd3);
    misaligned_req = ((bus.MemoryAccessWidth == W_HALF) && bus.Address[0]) ||
                     ((bus.MemoryAccessWidth == W_WORD) && (bus.Address[1:0] != 2'b00));
    case (bus.MemoryAccessWidth)
      W_BYTE: begin
        be_next    = 4'b0001 << bus.Address[1:0];
        wdata_next = {4{bus.StoreData[7:0]}};
      end
      W_HALF: begin
        be_next    = 4'b0011 << bus.Address[1:0];
        wdata_next = {2{bus.StoreData[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = bus.StoreData;
      end
    endcase
  end

  // Lane select from the latched byte offset; word accesses are aligned so the shift is zero.
  always_comb begin
    shifted = bus.RamReadData >> {lat_offset, 3'b000};
    case (lat_width)
      W_BYTE:  load_fmt = lat_sext ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      W_HALF:  load_fmt = lat_sext ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state              <= ST_IDLE;
      lat_write          <= 1'b0;
      lat_width          <= 2'd0;
      lat_sext           <= 1'b0;
      lat_offset         <= 2'd0;
      bus.Busy           <= 1'b0;
      bus.Done           <= 1'b0;
      bus.LoadResult     <= 32'h0;
      bus.FaultCode      <= FAULT_NONE;
      bus.RamRequest     <= 1'b0;
      bus.RamWriteEnable <= 1'b0;
      bus.RamAddress     <= 30'h0;
      bus.RamByteEnable  <= 4'h0;
      bus.RamWriteData   <= 32'h0;
`ifdef LOAD_STORE_TIMEOUT_EN
      wait_count         <= 8'h0;
`endif
    end else begin
      bus.Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            lat_write  <= bus.IsMemoryWrite;
            lat_width  <= bus.MemoryAccessWidth;
            lat_sext   <= bus.MemoryAccessSignExtend;
            lat_offset <= bus.Address[1:0];
            bus.Busy   <= 1'b1;
            if (invalid_req) begin
              state         <= ST_RESPOND;
              bus.Done      <= 1'b1;
              bus.FaultCode <= FAULT_INVALID;
            end else if (misaligned_req) begin
              state         <= ST_RESPOND;
              bus.Done      <= 1'b1;
              bus.FaultCode <= FAULT_MISALIGNED;
            end else begin
              state              <= ST_ACCESS;
              bus.RamRequest     <= 1'b1;
              bus.RamWriteEnable <= bus.IsMemoryWrite;
              bus.RamAddress     <= bus.Address[31:2];
              bus.RamByteEnable  <= be_next;
              bus.RamWriteData   <= wdata_next;
`ifdef LOAD_STORE_TIMEOUT_EN
              wait_count         <= 8'h0;
`endif
            end
          end
        end
        ST_ACCESS: begin
          if (bus.RamReady) begin
            state          <= ST_RESPOND;
            bus.RamRequest <= 1'b0;
            bus.Done       <= 1'b1;
            bus.FaultCode  <= FAULT_NONE;
            if (!lat_write) begin
              bus.LoadResult <= load_fmt;
            end
          end
`ifdef LOAD_STORE_TIMEOUT_EN
          else if (wait_count == TIMEOUT_LAST) begin
            state          <= ST_RESPOND;
            bus.RamRequest <= 1'b0;
            bus.Done       <= 1'b1;
            bus.FaultCode  <= FAULT_TIMEOUT;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
`endif
        end
        ST_RESPOND: begin
          state    <= ST_IDLE;
          bus.Busy <= 1'b0;
        end
        default: begin
          state          <= ST_IDLE;
          bus.Busy       <= 1'b0;
          bus.RamRequest <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_controller.sv
// tb/tb_load_store_controller.sv - directed vector bench for load_store_controller
module tb_load_store_controller;

`ifdef LOAD_STORE_TIMEOUT_EN
  localparam int unsigned TO     = 4;
  localparam int          WAIT_N = 3;
`else
  localparam int unsigned TO     = 64;
  localparam int          WAIT_N = 5;
`endif

  logic Clock;
  logic ResetN;
  load_store_controller_if bus();

  load_store_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  width;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [1:0]  fault;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] lr;
  } vec_t;

  vec_t vecs[13];
  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [1:0] width,
                         input logic sext, input logic [31:0] addr, input logic [31:0] sdata);
    bus.IsMemoryRead           = rd;
    bus.IsMemoryWrite          = wr;
    bus.MemoryAccessWidth      = width;
    bus.MemoryAccessSignExtend = sext;
    bus.Address                = addr;
    bus.StoreData              = sdata;
  endtask

  initial begin
    int req_cycles;
    int done_seen;
    checks   = 0;
    failures = 0;

    //             rd    wr    width sext  addr          sdata         rdata         flt   be       wdata         lr
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h00000103, 32'h00000000, 32'h80112233, 2'd0, 4'b1000, 32'h00000000, 32'hFFFFFF80};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h00000202, 32'hDEADBEEF, 32'h00000000, 2'd0, 4'b1100, 32'hBEEFBEEF, 32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h00000101, 32'h00000000, 32'h11228344, 2'd0, 4'b0010, 32'h00000000, 32'h00000083};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h00000000, 32'h00000000, 32'h1234F00D, 2'd0, 4'b0011, 32'h00000000, 32'hFFFFF00D};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h00000010, 32'h00000000, 32'h87654321, 2'd0, 4'b1111, 32'h00000000, 32'h87654321};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h00000003, 32'h000000A7, 32'h00000000, 2'd0, 4'b1000, 32'hA7A7A7A7, 32'h87654321};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h00000008, 32'hCAFEF00D, 32'h00000000, 2'd0, 4'b1111, 32'hCAFEF00D, 32'h87654321};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h00000006, 32'h00000000, 32'hFFFFFFFF, 2'd1, 4'b0000, 32'h00000000, 32'h87654321};
    vecs[8]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h00000003, 32'h00000000, 32'hFFFFFFFF, 2'd1, 4'b0000, 32'h00000000, 32'h87654321};
    vecs[9]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 2'd3, 4'b0000, 32'h00000000, 32'h87654321};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 2'd3, 4'b0000, 32'h00000000, 32'h87654321};
    vecs[11] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 2'd3, 4'b0000, 32'h00000000, 32'h87654321};
    vecs[12] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h00000002, 32'h00000000, 32'hFFFF0000, 2'd0, 4'b1100, 32'h00000000, 32'h0000FFFF};

    ResetN          = 1'b0;
    bus.Start       = 1'b0;
    bus.RamReady    = 1'b0;
    bus.RamReadData = 32'h0;
    set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    step(); step(); step();
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    chk("rst_done", 32'(bus.Done), 32'h0);
    chk("rst_req", 32'(bus.RamRequest), 32'h0);
    chk("rst_we", 32'(bus.RamWriteEnable), 32'h0);
    chk("rst_be", 32'(bus.RamByteEnable), 32'h0);
    chk("rst_addr", 32'(bus.RamAddress), 32'h0);
    chk("rst_wdata", bus.RamWriteData, 32'h0);
    chk("rst_lr", bus.LoadResult, 32'h0);
    chk("rst_fault", 32'(bus.FaultCode), 32'h0);
    ResetN = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      set_req(vecs[i].rd, vecs[i].wr, vecs[i].width, vecs[i].sext, vecs[i].addr, vecs[i].sdata);
      bus.RamReady    = 1'b1;
      bus.RamReadData = vecs[i].rdata;
      bus.Start       = 1'b1;
      step();
      bus.Start = 1'b0;
      if (vecs[i].fault == 2'd0) begin
        chk($sformatf("v%0d_req", i), 32'(bus.RamRequest), 32'h1);
        chk($sformatf("v%0d_ramaddr", i), 32'(bus.RamAddress), 32'(vecs[i].addr[31:2]));
        chk($sformatf("v%0d_be", i), 32'(bus.RamByteEnable), 32'(vecs[i].be));
        chk($sformatf("v%0d_wdata", i), bus.RamWriteData, vecs[i].wdata);
        chk($sformatf("v%0d_we", i), 32'(bus.RamWriteEnable), 32'(vecs[i].wr));
        chk($sformatf("v%0d_early_done", i), 32'(bus.Done), 32'h0);
        step();
      end
      chk($sformatf("v%0d_req_resp", i), 32'(bus.RamRequest), 32'h0);
      chk($sformatf("v%0d_done", i), 32'(bus.Done), 32'h1);
      chk($sformatf("v%0d_busy_resp", i), 32'(bus.Busy), 32'h1);
      chk($sformatf("v%0d_fault", i), 32'(bus.FaultCode), 32'(vecs[i].fault));
      chk($sformatf("v%0d_lr", i), bus.LoadResult, vecs[i].lr);
      step();
      chk($sformatf("v%0d_done_clr", i), 32'(bus.Done), 32'h0);
      chk($sformatf("v%0d_idle", i), 32'(bus.Busy), 32'h0);
      chk($sformatf("v%0d_fault_hold", i), 32'(bus.FaultCode), 32'(vecs[i].fault));
    end

    // RAM wait with a second Start mid-wait that must be ignored
    bus.RamReady    = 1'b0;
    bus.RamReadData = 32'hA5A51234;
    set_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h00000002, 32'h0);
    bus.Start = 1'b1;
    step();
    bus.Start  = 1'b0;
    req_cycles = (bus.RamRequest === 1'b1) ? 1 : 0;
    done_seen  = 0;
    for (int k = 0; k < WAIT_N; k++) begin
      if (k == 1) begin
        set_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h00000040, 32'h12345678);
        bus.Start = 1'b1;
      end
      step();
      bus.Start = 1'b0;
      if (bus.RamRequest === 1'b1) req_cycles++;
      if (bus.Done === 1'b1) done_seen++;
    end
    chk("wait_no_done", 32'(done_seen), 32'h0);
    chk("wait_we_kept", 32'(bus.RamWriteEnable), 32'h0);
    chk("wait_addr_kept", 32'(bus.RamAddress), 32'h0);
    bus.RamReady = 1'b1;
    step();
    if (bus.RamRequest === 1'b1) req_cycles++;
    chk("wait_req_cycles", 32'(req_cycles), 32'(WAIT_N + 1));
    chk("wait_done", 32'(bus.Done), 32'h1);
    chk("wait_lr", bus.LoadResult, 32'h0000A5A5);
    step();
    chk("wait_idle", 32'(bus.Busy), 32'h0);

    // Start held through the RESPOND cycle is dropped
    set_req(1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    bus.Start = 1'b1;
    step();
    chk("resp_done", 32'(bus.Done), 32'h1);
    chk("resp_fault", 32'(bus.FaultCode), 32'h3);
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    step();
    bus.Start = 1'b0;
    chk("resp_drop_busy", 32'(bus.Busy), 32'h0);
    chk("resp_drop_req", 32'(bus.RamRequest), 32'h0);
    step();
    chk("resp_drop_req2", 32'(bus.RamRequest), 32'h0);
    chk("resp_drop_done", 32'(bus.Done), 32'h0);

`ifdef LOAD_STORE_TIMEOUT_EN
    bus.RamReady = 1'b0;
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000020, 32'h0);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.Done === 1'b1) done_seen++;
    end
    chk("to_no_early_done", 32'(done_seen), 32'h0);
    chk("to_req_waiting", 32'(bus.RamRequest), 32'h1);
    step();
    chk("to_done", 32'(bus.Done), 32'h1);
    chk("to_fault", 32'(bus.FaultCode), 32'h2);
    chk("to_req_drop", 32'(bus.RamRequest), 32'h0);
    chk("to_lr_kept", bus.LoadResult, 32'h0000A5A5);
    step();
`else
    bus.RamReady    = 1'b0;
    bus.RamReadData = 32'h13579BDF;
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000020, 32'h0);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (bus.Done === 1'b1 || bus.FaultCode === 2'd2) done_seen++;
    end
    chk("nto_no_done", 32'(done_seen), 32'h0);
    chk("nto_req_held", 32'(bus.RamRequest), 32'h1);
    bus.RamReady = 1'b1;
    step();
    chk("nto_done", 32'(bus.Done), 32'h1);
    chk("nto_fault", 32'(bus.FaultCode), 32'h0);
    chk("nto_lr", bus.LoadResult, 32'h13579BDF);
    step();
`endif

    // Reset while ACCESS is waiting abandons the access without Done
    bus.RamReady = 1'b0;
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000044, 32'h0);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("rsta_req", 32'(bus.RamRequest), 32'h1);
    ResetN = 1'b0;
    step();
    chk("rsta_req_low", 32'(bus.RamRequest), 32'h0);
    chk("rsta_busy_low", 32'(bus.Busy), 32'h0);
    chk("rsta_lr_clr", bus.LoadResult, 32'h0);
    ResetN       = 1'b1;
    bus.RamReady = 1'b1;
    done_seen    = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.Done === 1'b1 || bus.RamRequest === 1'b1) done_seen++;
    end
    chk("rsta_no_done", 32'(done_seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
